// File: rtl/audio_clock_gen.sv
// audio_clock_gen: divides the audio PLL refclk into BCLK/LRCLK plus bit and frame strobes.
// Define AUDIO_CLKGEN_TDM_EN for multi-slot TDM framing with a one-BCLK sync pulse on lrclk.
module audio_clock_gen #(
  parameter int SLOT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int HALF_DIV0  = 1,
  parameter int HALF_DIV1  = 2,
  parameter int HALF_DIV2  = 5,
  parameter int HALF_DIV3  = 11
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    rate_sel,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          bclk_rise,
  output logic                          bclk_fall,
  output logic                          frame_start,
  output logic [$clog2(CHANNELS)-1:0]   slot_idx,
  output logic [$clog2(SLOT_WIDTH)-1:0] bit_idx,
  output logic                          ready
);

  localparam int BW     = $clog2(SLOT_WIDTH);
  localparam int SW     = $clog2(CHANNELS);
  localparam int MAX01  = (HALF_DIV0 > HALF_DIV1) ? HALF_DIV0 : HALF_DIV1;
  localparam int MAX23  = (HALF_DIV2 > HALF_DIV3) ? HALF_DIV2 : HALF_DIV3;
  localparam int MAXDIV = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int CW     = (MAXDIV > 0) ? $clog2(MAXDIV + 1) : 1;
  localparam logic [BW-1:0] BIT_TOP  = BW'(SLOT_WIDTH - 1);
  localparam logic [SW-1:0] SLOT_TOP = SW'(CHANNELS - 1);

  if (SLOT_WIDTH < 8 || SLOT_WIDTH > 32) begin : g_slotWidthCheck
    $error("audio_clock_gen: SLOT_WIDTH must be in 8..32");
  end
`ifdef AUDIO_CLKGEN_TDM_EN
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_channelCheck
    $error("audio_clock_gen: CHANNELS must be in 2..16");
  end
`else
  if (CHANNELS != 2) begin : g_channelCheck
    $error("audio_clock_gen: CHANNELS must be 2 without AUDIO_CLKGEN_TDM_EN");
  end
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] halfCnt_q, halfCnt_d;
  logic [1:0]    activeRate_q, activeRate_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          bclkRise_q, bclkRise_d;
  logic          bclkFall_q, bclkFall_d;
  logic          frameStart_q, frameStart_d;
  logic [SW-1:0] slotIdx_q, slotIdx_d;
  logic [BW-1:0] bitIdx_q, bitIdx_d;
  logic          ready_q, ready_d;

  function automatic logic [CW-1:0] halfDiv(input logic [1:0] r);
    case (r)
      2'd0:    halfDiv = CW'(HALF_DIV0);
      2'd1:    halfDiv = CW'(HALF_DIV1);
      2'd2:    halfDiv = CW'(HALF_DIV2);
      default: halfDiv = CW'(HALF_DIV3);
    endcase
  endfunction

  // The frame-boundary falling edge is where a pending rate request takes effect,
  // so the reload there already uses the new divider for the whole next frame.
  always_comb begin
    state_d      = state_q;
    halfCnt_d    = halfCnt_q;
    activeRate_d = activeRate_q;
    bclk_d       = bclk_q;
    lrclk_d      = lrclk_q;
    bclkRise_d   = 1'b0;
    bclkFall_d   = 1'b0;
    frameStart_d = 1'b0;
    slotIdx_d    = slotIdx_q;
    bitIdx_d     = bitIdx_q;
    ready_d      = ready_q;
    case (state_q)
      IDLE: begin
        activeRate_d = rate_sel;
        if (en) begin
          state_d      = RUN;
          halfCnt_d    = halfDiv(rate_sel);
          bclkFall_d   = 1'b1;
          frameStart_d = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d      = IDLE;
          halfCnt_d    = '0;
          activeRate_d = rate_sel;
          bclk_d       = 1'b0;
          lrclk_d      = 1'b0;
          slotIdx_d    = '0;
          bitIdx_d     = BIT_TOP;
          ready_d      = 1'b0;
        end else begin
          if (rate_sel != activeRate_q) begin
            ready_d = 1'b0;
          end
          if (halfCnt_q != '0) begin
            halfCnt_d = halfCnt_q - CW'(1);
          end else begin
            halfCnt_d = halfDiv(activeRate_q);
            bclk_d    = ~bclk_q;
            if (!bclk_q) begin
              bclkRise_d = 1'b1;
            end else begin
              bclkFall_d = 1'b1;
              if (bitIdx_q == '0) begin
                bitIdx_d = BIT_TOP;
                if (slotIdx_q == SLOT_TOP) begin
                  slotIdx_d    = '0;
                  frameStart_d = 1'b1;
                  if (rate_sel != activeRate_q) begin
                    activeRate_d = rate_sel;
                    halfCnt_d    = halfDiv(rate_sel);
                    ready_d      = 1'b0;
                  end else begin
                    ready_d = 1'b1;
                  end
                end else begin
                  slotIdx_d = slotIdx_q + SW'(1);
                end
              end else begin
                bitIdx_d = bitIdx_q - BW'(1);
              end
`ifdef AUDIO_CLKGEN_TDM_EN
              lrclk_d = (bitIdx_q == BW'(1)) && (slotIdx_q == SLOT_TOP);
`else
              // I2S word select changes one BCLK ahead of the next slot's MSB.
              if (bitIdx_q == BW'(1)) begin
                lrclk_d = (slotIdx_q == '0);
              end
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      halfCnt_q    <= '0;
      activeRate_q <= 2'd0;
      bclk_q       <= 1'b0;
      lrclk_q      <= 1'b0;
      bclkRise_q   <= 1'b0;
      bclkFall_q   <= 1'b0;
      frameStart_q <= 1'b0;
      slotIdx_q    <= '0;
      bitIdx_q     <= BIT_TOP;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      halfCnt_q    <= halfCnt_d;
      activeRate_q <= activeRate_d;
      bclk_q       <= bclk_d;
      lrclk_q      <= lrclk_d;
      bclkRise_q   <= bclkRise_d;
      bclkFall_q   <= bclkFall_d;
      frameStart_q <= frameStart_d;
      slotIdx_q    <= slotIdx_d;
      bitIdx_q     <= bitIdx_d;
      ready_q      <= ready_d;
    end
  end

  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign bclk_rise   = bclkRise_q;
  assign bclk_fall   = bclkFall_q;
  assign frame_start = frameStart_q;
  assign slot_idx    = slotIdx_q;
  assign bit_idx     = bitIdx_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_audio_clock_gen.sv
// tb_audio_clock_gen: scoreboard bench for audio_clock_gen at default parameters, driven
// by a table of run segments plus a hand-written asynchronous-reset sequence.
module tb_audio_clock_gen;

  localparam int SW = 32;
  localparam int CH = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] rate_sel;
  logic       bclk, lrclk, bclk_rise, bclk_fall, frame_start, ready;
  logic [0:0] slot_idx;
  logic [4:0] bit_idx;

  audio_clock_gen dut (
    .refclk      (refclk),
    .rst         (rst),
    .en          (en),
    .rate_sel    (rate_sel),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .bclk_rise   (bclk_rise),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start),
    .slot_idx    (slot_idx),
    .bit_idx     (bit_idx),
    .ready       (ready)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       bclk;
    logic       lrclk;
    logic       rise;
    logic       fall;
    logic       fs;
    logic       ready;
    logic [0:0] slot;
    logic [4:0] bitIdx;
  } outs_t;

  typedef struct {
    logic       en;
    logic [1:0] rate;
    int         cycles;
    int         expFrames;
    logic       expReadyEnd;
  } seg_t;

  outs_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;

  // Reference model state: position within the frame rather than divider counters.
  bit         mRun;
  int         mT;
  logic [1:0] mRate;
  bit         mReady;

  function automatic int halfOf(input logic [1:0] r);
    case (r)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 5;
      default: return 11;
    endcase
  endfunction

  function automatic int frameLen(input logic [1:0] r);
    return CH * SW * 2 * (halfOf(r) + 1);
  endfunction

  function automatic outs_t idleOuts();
    outs_t o;
    o = '0;
    o.bitIdx = 5'(SW - 1);
    return o;
  endfunction

  function automatic outs_t runOuts(input int t, input logic [1:0] r, input bit rdy);
    outs_t o;
    int p, ph, bc;
    p  = 2 * (halfOf(r) + 1);
    ph = t % p;
    bc = t / p;
    o.bclk   = (ph >= halfOf(r) + 1);
    o.rise   = (ph == halfOf(r) + 1);
    o.fall   = (ph == 0);
    o.fs     = (t == 0);
    o.ready  = rdy;
    o.slot   = 1'(bc / SW);
    o.bitIdx = 5'(SW - 1 - (bc % SW));
`ifdef AUDIO_CLKGEN_TDM_EN
    o.lrclk  = (bc == CH * SW - 1);
`else
    o.lrclk  = (((bc + 1) / SW) % 2) == 1;
`endif
    return o;
  endfunction

  task automatic modelReset();
    mRun   = 1'b0;
    mT     = 0;
    mRate  = 2'd0;
    mReady = 1'b0;
  endtask

  task automatic modelStep(input logic e, input logic [1:0] r);
    if (!mRun) begin
      mRate = r;
      if (e) begin
        mRun   = 1'b1;
        mT     = 0;
        mReady = 1'b0;
      end
    end else if (!e) begin
      mRun   = 1'b0;
      mReady = 1'b0;
      mRate  = r;
    end else begin
      if (r != mRate) mReady = 1'b0;
      mT++;
      if (mT == frameLen(mRate)) begin
        mT = 0;
        if (r != mRate) begin
          mRate  = r;
          mReady = 1'b0;
        end else begin
          mReady = 1'b1;
        end
      end
    end
    expQ.push_back(mRun ? runOuts(mT, mRate, mReady) : idleOuts());
  endtask

  task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic outs_t sampleOuts();
    outs_t o;
    o.bclk   = bclk;
    o.lrclk  = lrclk;
    o.rise   = bclk_rise;
    o.fall   = bclk_fall;
    o.fs     = frame_start;
    o.ready  = ready;
    o.slot   = slot_idx;
    o.bitIdx = bit_idx;
    return o;
  endfunction

  task automatic checkOutput();
    outs_t expOut;
    if (expQ.size() == 0) begin
      compareVal("scoreboard empty", 32'(expQ.size()), 32'd1);
    end else begin
      expOut = expQ.pop_front();
      compareVal("outputs", 32'(sampleOuts()), 32'(expOut));
    end
    compareVal("rise/fall overlap", 32'(bclk_rise & bclk_fall), 32'd0);
    compareVal("frame_start without bclk_fall", 32'(frame_start & ~bclk_fall), 32'd0);
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] r);
    en       = e;
    rate_sel = r;
    @(posedge refclk);
    modelStep(e, r);
    @(negedge refclk);
    checkOutput();
  endtask

  seg_t segs[6];

  initial begin
    int fsCount;

    // rate 0: 256-cycle frames; rate 3: 1536-cycle frames.
    segs[0] = '{en: 1'b0, rate: 2'd0, cycles: 5,    expFrames: 0, expReadyEnd: 1'b0};
    segs[1] = '{en: 1'b1, rate: 2'd0, cycles: 600,  expFrames: 3, expReadyEnd: 1'b1};
    segs[2] = '{en: 1'b1, rate: 2'd3, cycles: 3241, expFrames: 3, expReadyEnd: 1'b1};
    segs[3] = '{en: 1'b1, rate: 2'd3, cycles: 700,  expFrames: 0, expReadyEnd: 1'b1};
    segs[4] = '{en: 1'b0, rate: 2'd0, cycles: 10,   expFrames: 0, expReadyEnd: 1'b0};
    segs[5] = '{en: 1'b1, rate: 2'd0, cycles: 520,  expFrames: 3, expReadyEnd: 1'b1};

    rst      = 1'b1;
    en       = 1'b0;
    rate_sel = 2'd0;
    modelReset();
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    compareVal("reset state", 32'(sampleOuts()), 32'(idleOuts()));
    rst = 1'b0;

    for (int s = 0; s < 6; s++) begin
      fsCount = 0;
      for (int k = 0; k < segs[s].cycles; k++) begin
        applyStimulus(segs[s].en, segs[s].rate);
        if (frame_start) fsCount++;
      end
      compareVal($sformatf("seg%0d frame count", s), 32'(fsCount), 32'(segs[s].expFrames));
      compareVal($sformatf("seg%0d ready at end", s), 32'(ready), 32'(segs[s].expReadyEnd));
    end

    // Last segment ends 7 cycles into a rate-0 frame: BCLK is in its high phase.
    compareVal("bclk high before reset", 32'(bclk), 32'd1);
    #1 rst = 1'b1;
    #1;
    compareVal("async reset outputs", 32'(sampleOuts()), 32'(idleOuts()));
    expQ.delete();
    modelReset();
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    compareVal("outputs held in reset", 32'(sampleOuts()), 32'(idleOuts()));
    rst = 1'b0;

    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 2'd2);
    fsCount = 0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'b1, 2'd2);
      if (frame_start) fsCount++;
    end
    compareVal("rate2 restart frame count", 32'(fsCount), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
